// File: rtl/sync_serializer.sv
// Phase-locked 4:1 serializer: checks the clock generator's sync phase, buffers
// words in a 2-entry FIFO and sends each as four sync-aligned serial beats.
module sync_serializer #(
  parameter int unsigned LANES    = 2,
  parameter int unsigned LOCK_CNT = 4,
  parameter logic        IDLE_BIT = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         sync,
  input  logic [4*LANES-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [LANES-1:0]   ser_data,
  output logic               ser_valid,
  output logic               frame_start,
  output logic               locked,
  output logic               sync_err
);
  localparam int unsigned WW = 4 * LANES;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {UNLOCKED, LOCKING, LOCKED_S} state_e;

  state_e        state_q;
  logic [1:0]    prev_sync_q;
  logic [CW-1:0] cnt_q;
  logic          locked_q, sync_err_q;

  logic          match_c, run_c, drop_c, boundary_c;
  logic          push_c, pop_c, avail_c;
  logic [WW-1:0] head_c;

  logic [WW-1:0]    mem_q [2];
  logic             rd_q, rd_d, wr_q, wr_d;
  logic [1:0]       occ_q, occ_d;
  logic             in_ready_q, in_ready_d;
  logic [WW-1:0]    frame_q, frame_d;
  logic             active_q, active_d;
  logic [LANES-1:0] ser_data_q, ser_data_d;
  logic             ser_valid_q, ser_valid_d;
  logic             frame_start_q, frame_start_d;

  assign match_c    = (sync == 2'(prev_sync_q + 2'd1));
  assign run_c      = (state_q == LOCKED_S) && match_c;
  assign drop_c     = (state_q == LOCKED_S) && !match_c;
  assign boundary_c = run_c && (sync == 2'd3);
  assign push_c     = in_valid && in_ready_q;
  // An empty FIFO forwards a word pushed on the boundary edge straight into the frame.
  assign avail_c    = (occ_q != 2'd0) || push_c;
  assign pop_c      = boundary_c && avail_c;
  assign head_c     = (occ_q == 2'd0) ? in_data : mem_q[rd_q];

  // Lock FSM: acquisition counts consecutive +1 steps of sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= UNLOCKED;
      prev_sync_q <= 2'd0;
      cnt_q       <= '0;
      locked_q    <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      prev_sync_q <= sync;
      sync_err_q  <= 1'b0;
      case (state_q)
        UNLOCKED: begin
          state_q <= LOCKING;
          cnt_q   <= '0;
        end
        LOCKING: begin
          if (!match_c) begin
            cnt_q <= '0;
          end else if (CW'(cnt_q + 1'b1) == CW'(LOCK_CNT)) begin
            state_q  <= LOCKED_S;
            cnt_q    <= CW'(LOCK_CNT);
            locked_q <= 1'b1;
          end else begin
            cnt_q <= CW'(cnt_q + 1'b1);
          end
        end
        LOCKED_S: begin
          if (!match_c) begin
            state_q    <= LOCKING;
            cnt_q      <= '0;
            locked_q   <= 1'b0;
            sync_err_q <= 1'b1;
          end
        end
        default: state_q <= UNLOCKED;
      endcase
    end
  end

  // FIFO bookkeeping, frame register and serial beat selection.
  always_comb begin
    logic [3:0] nib;
    nib           = 4'd0;
    rd_d          = pop_c ? ~rd_q : rd_q;
    wr_d          = push_c ? ~wr_q : wr_q;
    occ_d         = 2'(occ_q + 2'(push_c) - 2'(pop_c));
    frame_d       = frame_q;
    active_d      = active_q;
    ser_data_d    = {LANES{IDLE_BIT}};
    ser_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    if (drop_c) begin
      active_d = 1'b0;
      frame_d  = '0;
    end else if (run_c) begin
      if (active_q) begin
        for (int l = 0; l < LANES; l++) begin
          nib           = frame_q[4*l +: 4];
          ser_data_d[l] = nib[sync];
        end
        ser_valid_d   = 1'b1;
        frame_start_d = (sync == 2'd0);
      end
      if (boundary_c) begin
        active_d = avail_c;
        if (avail_c) frame_d = head_c;
      end
    end
    in_ready_d = (occ_d != 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0]      <= '0;
      mem_q[1]      <= '0;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      occ_q         <= 2'd0;
      in_ready_q    <= 1'b1;
      frame_q       <= '0;
      active_q      <= 1'b0;
      ser_data_q    <= {LANES{IDLE_BIT}};
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      if (push_c) mem_q[wr_q] <= in_data;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      occ_q         <= occ_d;
      in_ready_q    <= in_ready_d;
      frame_q       <= frame_d;
      active_q      <= active_d;
      ser_data_q    <= ser_data_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign ser_data    = ser_data_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign sync_err    = sync_err_q;
endmodule

// File: tb/tb_sync_serializer.sv
// Self-checking bench for sync_serializer: random words and sync disturbances
// compared against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_sync_serializer;
  localparam int unsigned LANES    = 2;
  localparam int unsigned LOCK_CNT = 4;
  localparam int unsigned WW       = 4 * LANES;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       sync = 2'd0;
  logic [WW-1:0]    in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [LANES-1:0] ser_data;
  logic             ser_valid, frame_start, locked, sync_err;

  logic             in_valid1 = 1'b0;
  logic             in_ready1;
  logic [LANES-1:0] ser_data1;
  logic             ser_valid1, frame_start1, locked1, sync_err1;

  sync_serializer #(.LANES(LANES), .LOCK_CNT(LOCK_CNT), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .sync(sync), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ser_data(ser_data), .ser_valid(ser_valid),
    .frame_start(frame_start), .locked(locked), .sync_err(sync_err));

  sync_serializer #(.LANES(LANES), .LOCK_CNT(LOCK_CNT), .IDLE_BIT(1'b1)) dut_idle1 (
    .clk(clk), .rst_n(rst_n), .sync(sync), .in_data(in_data), .in_valid(in_valid1),
    .in_ready(in_ready1), .ser_data(ser_data1), .ser_valid(ser_valid1),
    .frame_start(frame_start1), .locked(locked1), .sync_err(sync_err1));

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int ph     = 0;

  // Behavioural model state
  bit               m_first;
  int               m_good;
  bit               m_locked;
  bit               m_active;
  bit               m_pushed;
  int               m_prev;
  logic [WW-1:0]    m_cur;
  logic [WW-1:0]    m_q[$];
  logic [LANES-1:0] exp_ser;
  bit               exp_valid, exp_fs, exp_locked, exp_err, exp_ready;
  logic [WW-1:0]    src[$];

  function automatic logic [6:0] obs();
    return {ser_data, ser_valid, frame_start, locked, sync_err, in_ready};
  endfunction

  function automatic logic [6:0] expv();
    return {exp_ser, exp_valid, exp_fs, exp_locked, exp_err, exp_ready};
  endfunction

  function automatic void model_reset();
    m_first = 1'b1; m_good = 0; m_locked = 1'b0; m_active = 1'b0; m_prev = 0;
    m_cur = '0; m_q.delete();
    exp_ser = '0; exp_valid = 1'b0; exp_fs = 1'b0; exp_locked = 1'b0;
    exp_err = 1'b0; exp_ready = 1'b1;
  endfunction

  // One clock edge of the link as seen from outside: lock tracking, word queue, beat output.
  function automatic void model_edge(input int s, input bit v, input logic [WW-1:0] d);
    bit push, match, done;
    push = v && exp_ready;
    done = 1'b0;
    m_pushed = push;
    exp_err = 1'b0; exp_valid = 1'b0; exp_fs = 1'b0; exp_ser = '0;
    if (m_first) begin
      m_first = 1'b0;
      m_good  = 0;
    end else begin
      match = (s == (m_prev + 1) % 4);
      if (!m_locked) begin
        m_good = match ? m_good + 1 : 0;
        if (m_good == LOCK_CNT) m_locked = 1'b1;
      end else if (!match) begin
        m_locked = 1'b0; m_good = 0; exp_err = 1'b1; m_active = 1'b0; m_cur = '0;
      end else begin
        if (m_active) begin
          for (int l = 0; l < LANES; l++) exp_ser[l] = m_cur[4*l + s];
          exp_valid = 1'b1;
          exp_fs    = (s == 0);
        end
        if (s == 3) begin
          if (push) begin m_q.push_back(d); done = 1'b1; end
          if (m_q.size() > 0) begin m_cur = m_q.pop_front(); m_active = 1'b1; end
          else m_active = 1'b0;
        end
      end
    end
    if (push && !done) m_q.push_back(d);
    exp_locked = m_locked;
    exp_ready  = (m_q.size() < 2);
    m_prev = s;
  endfunction

  task automatic step(input int glitch);
    sync = (glitch >= 0) ? 2'(glitch) : 2'(ph);
    if (src.size() > 0) begin in_valid = 1'b1; in_data = src[0]; end
    else begin in_valid = 1'b0; in_data = WW'($urandom); end
    @(posedge clk);
    model_edge(int'(sync), in_valid, in_data);
    if (m_pushed) void'(src.pop_front());
    ph = (ph + 1) % 4;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs() !== 7'b0000001) begin
      fails++; $display("FAIL reset_outputs: got %b want %b", obs(), 7'b0000001);
    end
    checks++;
    if ({ser_data1, ser_valid1, locked1, in_ready1} !== 5'b11001) begin
      fails++; $display("FAIL reset_idle1: got %b want %b", {ser_data1, ser_valid1, locked1, in_ready1}, 5'b11001);
    end
    model_reset();
  endtask

  task automatic test_lock();
    ph = 0;
    rst_n = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step(-1);
      checks++;
      if (locked !== 1'(n >= 5)) begin
        fails++; $display("FAIL lock_edge%0d: got %b want %b", n, locked, 1'(n >= 5));
      end
      checks++;
      if (obs() !== expv()) begin
        fails++; $display("FAIL lock_model edge%0d: got %b want %b", n, obs(), expv());
      end
      checks++;
      if (sync_err !== 1'b0 || ser_valid !== 1'b0) begin
        fails++; $display("FAIL lock_quiet edge%0d: got err=%b valid=%b want 0 0", n, sync_err, ser_valid);
      end
    end
  endtask

  task automatic test_idle();
    for (int n = 0; n < 8; n++) begin
      step(-1);
      checks++;
      if ({ser_data1, ser_valid1, frame_start1, locked1} !== 5'b11001) begin
        fails++; $display("FAIL idle_ones phase%0d: got %b want %b", n, {ser_data1, ser_valid1, frame_start1, locked1}, 5'b11001);
      end
    end
  endtask

  task automatic test_single_word();
    logic [LANES-1:0] beats[4];
    logic [LANES-1:0] want[4];
    logic [3:0]       fs_seen;
    int nb, first, last;
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01; want[3] = 2'b10;
    nb = 0; first = -1; last = -1; fs_seen = '0;
    src.push_back(8'hA5);
    for (int c = 0; c < 16; c++) begin
      step(-1);
      checks++;
      if (obs() !== expv()) begin
        fails++; $display("FAIL single_model cyc%0d: got %b want %b", c, obs(), expv());
      end
      if (ser_valid === 1'b1) begin
        if (nb < 4) begin beats[nb] = ser_data; fs_seen[nb] = frame_start; end
        if (first < 0) first = c;
        last = c; nb++;
      end
    end
    checks++;
    if (nb !== 4 || (last - first) !== 3) begin
      fails++; $display("FAIL single_count: got beats=%0d span=%0d want 4 3", nb, last - first);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (nb >= 4 && beats[k] !== want[k]) begin
        fails++; $display("FAIL single_beat%0d: got %b want %b", k, beats[k], want[k]);
      end
    end
    checks++;
    if (fs_seen !== 4'b0001) begin
      fails++; $display("FAIL single_frame_start: got %b want %b", fs_seen, 4'b0001);
    end
  endtask

  task automatic test_back_to_back();
    logic [WW-1:0] sent[$];
    logic [WW-1:0] rx[$];
    logic [WW-1:0] w;
    bit saw_stall;
    int nb, first, last, p;
    nb = 0; first = -1; last = -1; p = 0; saw_stall = 1'b0; w = '0;
    while (sent.size() < 6) begin
      logic [WW-1:0] cand;
      bit dup;
      cand = WW'($urandom);
      dup = 1'b0;
      foreach (sent[i]) if (sent[i] == cand) dup = 1'b1;
      if (!dup) sent.push_back(cand);
    end
    foreach (sent[i]) src.push_back(sent[i]);
    for (int c = 0; c < 60; c++) begin
      step(-1);
      checks++;
      if (obs() !== expv()) begin
        fails++; $display("FAIL b2b_model cyc%0d: got %b want %b", c, obs(), expv());
      end
      if (in_ready === 1'b0) saw_stall = 1'b1;
      if (ser_valid === 1'b1) begin
        if (frame_start === 1'b1) p = 0;
        for (int l = 0; l < LANES; l++) w[4*l + p] = ser_data[l];
        if (p == 3) rx.push_back(w);
        p = (p + 1) % 4;
        if (first < 0) first = c;
        last = c; nb++;
      end
    end
    checks++;
    if (!saw_stall) begin
      fails++; $display("FAIL b2b_backpressure: got in_ready never low want a stall");
    end
    checks++;
    if (nb !== 24 || (last - first) !== 23) begin
      fails++; $display("FAIL b2b_contiguous: got beats=%0d span=%0d want 24 23", nb, last - first);
    end
    checks++;
    if (rx.size() !== 6) begin
      fails++; $display("FAIL b2b_words: got %0d words want 6", rx.size());
    end else begin
      foreach (sent[i]) begin
        checks++;
        if (rx[i] !== sent[i]) begin
          fails++; $display("FAIL b2b_word%0d: got %h want %h", i, rx[i], sent[i]);
        end
      end
    end
  endtask

  task automatic test_sync_glitch();
    int errs, nvalid, c;
    bit found;
    errs = 0; nvalid = 0; found = 1'b0;
    for (int i = 0; i < 3; i++) src.push_back(WW'($urandom));
    for (c = 0; c < 40 && !found; c++) begin
      step(-1);
      if (ser_valid === 1'b1 && ph == 1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      fails++; $display("FAIL glitch_setup: got no active frame in 40 cycles want one");
    end
    step(2);
    checks++;
    if ({sync_err, locked, ser_valid} !== 3'b100) begin
      fails++; $display("FAIL glitch_drop: got err/lock/valid=%b want %b", {sync_err, locked, ser_valid}, 3'b100);
    end
    checks++;
    if (obs() !== expv()) begin
      fails++; $display("FAIL glitch_model: got %b want %b", obs(), expv());
    end
    for (int n = 0; n < 40; n++) begin
      step(-1);
      checks++;
      if (obs() !== expv()) begin
        fails++; $display("FAIL glitch_model cyc%0d: got %b want %b", n, obs(), expv());
      end
      if (sync_err === 1'b1) errs++;
      if (ser_valid === 1'b1) nvalid++;
    end
    checks++;
    if (errs !== 0 || locked !== 1'b1) begin
      fails++; $display("FAIL glitch_relock: got extra_err=%0d locked=%b want 0 1", errs, locked);
    end
    checks++;
    if (nvalid == 0 || (nvalid % 4) != 0) begin
      fails++; $display("FAIL glitch_frames: got %0d valid beats want a nonzero multiple of 4", nvalid);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit found;
    int stale;
    found = 1'b0; stale = 0;
    src.push_back(WW'($urandom));
    src.push_back(WW'($urandom));
    for (int c = 0; c < 40 && !found; c++) begin
      step(-1);
      if (ser_valid === 1'b1 && ph == 2) found = 1'b1;
    end
    checks++;
    if (!found) begin
      fails++; $display("FAIL midrst_setup: got no frame at phase 1 want one");
    end
    src.delete();
    in_valid = 1'b0;
    sync = 2'(ph);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 7'b0000001) begin
      fails++; $display("FAIL midrst_async: got %b want %b", obs(), 7'b0000001);
    end
    model_reset();
    ph = (ph + 1) % 4;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 14; n++) begin
      step(-1);
      checks++;
      if (obs() !== expv()) begin
        fails++; $display("FAIL midrst_model cyc%0d: got %b want %b", n, obs(), expv());
      end
      if (ser_valid === 1'b1) stale++;
    end
    checks++;
    if (stale !== 0) begin
      fails++; $display("FAIL midrst_stale: got %0d valid beats want 0", stale);
    end
  endtask

  task automatic test_random();
    int g;
    for (int n = 0; n < 600; n++) begin
      if (src.size() < 3 && $urandom_range(0, 2) == 0) src.push_back(WW'($urandom));
      g = -1;
      if ($urandom_range(0, 79) == 0) g = (ph + int'($urandom_range(2, 4))) % 4;
      step(g);
      checks++;
      if (obs() !== expv()) begin
        fails++; $display("FAIL random_model cyc%0d: got %b want %b", n, obs(), expv());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_idle();
    test_single_word();
    test_back_to_back();
    test_sync_glitch();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
